// File: rtl/chr_bus_arb.sv
`default_nettype none
// =====================================================================
// Module  : chr_bus_arb
// Brief   : CHR memory bus arbiter/sequencer; PPU fetches have priority
//           over the save-state DMA channel. Build macro
//           CHR_ARB_FAIRNESS_EN enables the DMA anti-starvation slot.
// Revision: 1.0 - initial release
// =====================================================================
module chr_bus_arb #(
  parameter int ACC_CYC    = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ppu_req,
  input  logic        ppu_we,
  input  logic [22:0] ppu_addr,
  input  logic [7:0]  ppu_wdat,
  output logic [7:0]  ppu_rdat,
  output logic        ppu_done,
  output logic        ppu_ovr,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [22:0] dma_addr,
  input  logic [7:0]  dma_wdat,
  output logic [7:0]  dma_rdat,
  output logic        dma_ack,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [7:0]  mem_wdat,
  input  logic [7:0]  mem_rdat
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PPU_ACC = 2'd1,
    S_DMA_ACC = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  localparam logic [3:0] c_last   = 4'(ACC_CYC - 1);
  // Last counter value from which mem_we is still high in the following cycle.
  localparam logic [3:0] c_we_end = 4'(ACC_CYC - 3);

  if (ACC_CYC < 3 || ACC_CYC > 15) begin : g_bad_acc_cyc
    $error("chr_bus_arb: ACC_CYC must be within 3..15");
  end
  if (STARVE_LIM < 1) begin : g_bad_starve_lim
    $error("chr_bus_arb: STARVE_LIM must be at least 1");
  end

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_pend;
  logic        r_p_we;
  logic [22:0] r_p_addr;
  logic [7:0]  r_p_wdat;

  logic        w_ppu_avail;
  logic        w_force;
  logic        w_grant_ppu;
  logic        w_grant_dma;
  logic        w_sel_we;
  logic [22:0] w_sel_addr;
  logic [7:0]  w_sel_wdat;

  // A held request takes precedence over a same-cycle pulse (which overruns).
  assign w_ppu_avail = r_pend | ppu_req;
  assign w_sel_we    = r_pend ? r_p_we   : ppu_we;
  assign w_sel_addr  = r_pend ? r_p_addr : ppu_addr;
  assign w_sel_wdat  = r_pend ? r_p_wdat : ppu_wdat;
  assign w_grant_ppu = (r_state == S_IDLE) && w_ppu_avail && !w_force;
  assign w_grant_dma = (r_state == S_IDLE) && !w_grant_ppu && dma_req;

`ifdef CHR_ARB_FAIRNESS_EN
  localparam int              c_sw  = $clog2(STARVE_LIM + 1);
  localparam logic [c_sw-1:0] c_lim = c_sw'(STARVE_LIM);

  logic [c_sw-1:0] r_starve;

  assign w_force = dma_req && (r_starve == c_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_grant_ppu) begin
      if (dma_req && (r_starve != c_lim)) r_starve <= r_starve + 1'b1;
    end else if (w_grant_dma) begin
      r_starve <= '0;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_pend   <= 1'b0;
      r_p_we   <= 1'b0;
      r_p_addr <= 23'd0;
      r_p_wdat <= 8'd0;
      mem_ce   <= 1'b0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 23'd0;
      mem_wdat <= 8'd0;
      ppu_rdat <= 8'd0;
      dma_rdat <= 8'd0;
      ppu_done <= 1'b0;
      dma_ack  <= 1'b0;
      ppu_ovr  <= 1'b0;
    end else begin
      ppu_done <= 1'b0;
      dma_ack  <= 1'b0;

      if (ppu_req) begin
        if (r_pend) begin
          ppu_ovr <= 1'b1;
        end else begin
          r_pend   <= 1'b1;
          r_p_we   <= ppu_we;
          r_p_addr <= ppu_addr;
          r_p_wdat <= ppu_wdat;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_ppu) begin
            r_pend   <= 1'b0;
            r_we     <= w_sel_we;
            mem_addr <= w_sel_addr;
            mem_wdat <= w_sel_wdat;
            mem_ce   <= 1'b1;
            mem_oe   <= !w_sel_we;
            mem_we   <= 1'b0;
            r_cnt    <= 4'd0;
            r_state  <= S_PPU_ACC;
          end else if (w_grant_dma) begin
            r_we     <= dma_we;
            mem_addr <= dma_addr;
            mem_wdat <= dma_wdat;
            mem_ce   <= 1'b1;
            mem_oe   <= !dma_we;
            mem_we   <= 1'b0;
            r_cnt    <= 4'd0;
            r_state  <= S_DMA_ACC;
          end
        end

        S_PPU_ACC, S_DMA_ACC: begin
          if (r_cnt == c_last) begin
            mem_ce  <= 1'b0;
            mem_oe  <= 1'b0;
            mem_we  <= 1'b0;
            r_state <= S_RECOVER;
            if (r_state == S_PPU_ACC) begin
              ppu_rdat <= mem_rdat;
              ppu_done <= 1'b1;
            end else begin
              dma_rdat <= mem_rdat;
              dma_ack  <= 1'b1;
            end
          end else begin
            r_cnt  <= r_cnt + 4'd1;
            mem_we <= r_we && (r_cnt <= c_we_end);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chr_bus_arb.sv
`default_nettype none
// =====================================================================
// Module  : tb_chr_bus_arb
// Brief   : Directed self-checking bench for chr_bus_arb (ACC_CYC=4).
// Revision: 1.0 - initial release
// =====================================================================
module tb_chr_bus_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ppu_req, ppu_we;
  logic [22:0] ppu_addr;
  logic [7:0]  ppu_wdat, ppu_rdat;
  logic        ppu_done, ppu_ovr;
  logic        dma_req, dma_we;
  logic [22:0] dma_addr;
  logic [7:0]  dma_wdat, dma_rdat;
  logic        dma_ack;
  logic        mem_ce, mem_oe, mem_we;
  logic [22:0] mem_addr;
  logic [7:0]  mem_wdat, mem_rdat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chr_bus_arb #(.ACC_CYC(4), .STARVE_LIM(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdat(ppu_wdat),
    .ppu_rdat(ppu_rdat), .ppu_done(ppu_done), .ppu_ovr(ppu_ovr),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdat(dma_wdat),
    .dma_rdat(dma_rdat), .dma_ack(dma_ack),
    .mem_ce(mem_ce), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_wdat = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdat = '0;
    mem_rdat = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_ce, mem_oe, mem_we, mem_addr, mem_wdat, ppu_rdat, dma_rdat,
         ppu_done, dma_ack, ppu_ovr} !== 53'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ce=%b oe=%b we=%b addr=%h ovr=%b required all zero",
               mem_ce, mem_oe, mem_we, mem_addr, ppu_ovr);
    end
    do_reset();
    tick();
    checks++;
    if ({mem_ce, ppu_done, dma_ack} !== 3'b000) begin
      failures++;
      $display("FAIL idle_quiet: got ce=%b done=%b ack=%b required 000", mem_ce, ppu_done, dma_ack);
    end
  endtask

  task automatic test_ppu_read;
    logic [3:0] exp;
    do_reset();
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 23'h000123; mem_rdat = 8'h5A;
    for (int c = 1; c <= 6; c++) begin
      tick();
      ppu_req = 1'b0;
      exp = {(c <= 4), (c <= 4), 1'b0, (c == 5)};
      checks++;
      if ({mem_ce, mem_oe, mem_we, ppu_done} !== exp) begin
        failures++;
        $display("FAIL ppu_read_strobes cyc%0d: got ce/oe/we/done=%b required %b",
                 c, {mem_ce, mem_oe, mem_we, ppu_done}, exp);
      end
      if (c <= 4) begin
        checks++;
        if (mem_addr !== 23'h000123) begin
          failures++;
          $display("FAIL ppu_read_addr cyc%0d: got %h required 000123", c, mem_addr);
        end
      end
    end
    checks++;
    if (ppu_rdat !== 8'h5A) begin
      failures++;
      $display("FAIL ppu_read_data: got %h required 5a", ppu_rdat);
    end
  endtask

  task automatic test_dma_write;
    logic [4:0] exp;
    int acks;
    do_reset();
    acks = 0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 23'h400010; dma_wdat = 8'hC3;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = {(c <= 4), 1'b0, (c == 2 || c == 3), (c == 5), 1'b0};
      checks++;
      if ({mem_ce, mem_oe, mem_we, dma_ack, ppu_done} !== exp) begin
        failures++;
        $display("FAIL dma_write_strobes cyc%0d: got ce/oe/we/ack/done=%b required %b",
                 c, {mem_ce, mem_oe, mem_we, dma_ack, ppu_done}, exp);
      end
      if (c == 1) begin
        checks++;
        if ({mem_addr, mem_wdat} !== {23'h400010, 8'hC3}) begin
          failures++;
          $display("FAIL dma_write_bus: got addr=%h wdat=%h required 400010/c3", mem_addr, mem_wdat);
        end
      end
      if (dma_ack) begin
        acks++;
        dma_req = 1'b0;
      end
    end
    dma_req = 1'b0;
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("FAIL dma_write_ack_count: got %0d required 1", acks);
    end
  endtask

  task automatic test_ppu_behind_dma;
    int  ack_c, done_c;
    logic broken;
    do_reset();
    ack_c = -1; done_c = -1; broken = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h055000; mem_rdat = 8'h77;
    tick();
    if (!mem_ce || mem_addr !== 23'h055000) broken = 1'b1;
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 23'h02AAAA;
    for (int c = 2; c <= 14; c++) begin
      tick();
      ppu_req = 1'b0;
      if (c <= 4 && (!mem_ce || mem_addr !== 23'h055000)) broken = 1'b1;
      if (dma_ack && ack_c < 0) begin
        ack_c = c;
        dma_req = 1'b0;
        mem_rdat = 8'h3C;
      end
      if (ppu_done && done_c < 0) done_c = c;
    end
    checks++;
    if (broken !== 1'b0) begin
      failures++;
      $display("FAIL dma_unbroken: got broken=%b required 0", broken);
    end
    checks++;
    if (ack_c !== 5) begin
      failures++;
      $display("FAIL dma_ack_cycle: got %0d required 5", ack_c);
    end
    checks++;
    if (done_c !== 11) begin
      failures++;
      $display("FAIL ppu_worst_latency: got done at cycle %0d required 11", done_c);
    end
    checks++;
    if ({dma_rdat, ppu_rdat} !== {8'h77, 8'h3C}) begin
      failures++;
      $display("FAIL read_data_split: got dma=%h ppu=%h required 77/3c", dma_rdat, ppu_rdat);
    end
  endtask

  task automatic test_overrun;
    logic seen_a, seen_b;
    int dones;
    do_reset();
    seen_a = 1'b0; seen_b = 1'b0; dones = 0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h011111;
    tick();
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 23'h000AAA;
    tick();
    checks++;
    if (ppu_ovr !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first_req: got %b required 0", ppu_ovr);
    end
    ppu_addr = 23'h000BBB;
    tick();
    ppu_req = 1'b0;
    checks++;
    if (ppu_ovr !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set: got %b required 1", ppu_ovr);
    end
    for (int c = 4; c <= 16; c++) begin
      tick();
      if (dma_ack) dma_req = 1'b0;
      if (mem_ce && mem_addr === 23'h000AAA) seen_a = 1'b1;
      if (mem_ce && mem_addr === 23'h000BBB) seen_b = 1'b1;
      if (ppu_done) dones++;
    end
    checks++;
    if ({seen_a, seen_b} !== 2'b10) begin
      failures++;
      $display("FAIL ovr_addr_seen: got held=%b dropped=%b required 1/0", seen_a, seen_b);
    end
    checks++;
    if (ppu_ovr !== 1'b1 || dones !== 1) begin
      failures++;
      $display("FAIL ovr_sticky: got ovr=%b dones=%0d required 1/1", ppu_ovr, dones);
    end
  endtask

  task automatic test_back_to_back;
    int rise1, rise2, done2, dones, we_cyc;
    logic prev_ce;
    logic [7:0] wd_at_rise2;
    do_reset();
    rise1 = -1; rise2 = -1; done2 = -1; dones = 0; we_cyc = 0; prev_ce = 1'b0;
    wd_at_rise2 = 8'h00;
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 23'h000010; mem_rdat = 8'h11;
    for (int c = 1; c <= 14; c++) begin
      tick();
      ppu_req = 1'b0;
      if (mem_ce && !prev_ce) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) begin
          rise2 = c;
          wd_at_rise2 = mem_wdat;
        end
      end
      prev_ce = mem_ce;
      if (mem_we) we_cyc++;
      if (ppu_done) begin
        dones++;
        if (dones == 1) begin
          ppu_req = 1'b1; ppu_we = 1'b1; ppu_addr = 23'h000020; ppu_wdat = 8'hE7;
        end else if (done2 < 0) begin
          done2 = c;
        end
      end
    end
    checks++;
    if (rise1 !== 1 || rise2 !== 7) begin
      failures++;
      $display("FAIL b2b_period: got starts %0d,%0d required 1,7", rise1, rise2);
    end
    checks++;
    if (done2 !== 11 || ppu_ovr !== 1'b0) begin
      failures++;
      $display("FAIL b2b_recover_req: got done2=%0d ovr=%b required 11/0", done2, ppu_ovr);
    end
    checks++;
    if (we_cyc !== 2 || wd_at_rise2 !== 8'hE7) begin
      failures++;
      $display("FAIL b2b_write: got we_cycles=%0d wdat=%h required 2/e7", we_cyc, wd_at_rise2);
    end
  endtask

  task automatic test_priority;
    int dma_start;
    logic [22:0] first_addr;
    logic prev_ce;
    do_reset();
    dma_start = -1; prev_ce = 1'b0; first_addr = '0;
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 23'h000ABC;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h300000;
    for (int c = 1; c <= 12; c++) begin
      tick();
      ppu_req = 1'b0;
      if (c == 1) first_addr = mem_addr;
      if (mem_ce && !prev_ce && mem_addr === 23'h300000 && dma_start < 0) dma_start = c;
      prev_ce = mem_ce;
      if (dma_ack) dma_req = 1'b0;
    end
    dma_req = 1'b0;
    checks++;
    if (first_addr !== 23'h000ABC) begin
      failures++;
      $display("FAIL priority_ppu_first: got %h required 000abc", first_addr);
    end
    checks++;
    if (dma_start !== 7) begin
      failures++;
      $display("FAIL priority_dma_after: got start cycle %0d required 7", dma_start);
    end
  endtask

  task automatic test_starvation;
    int pg, dg, pg_at_dma;
    logic prev_ce;
    do_reset();
    pg = 0; dg = 0; pg_at_dma = -1; prev_ce = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h7FFFF0;
    ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 23'h000100;
    for (int c = 1; c <= 100; c++) begin
      tick();
      ppu_req = 1'b0;
      if (mem_ce && !prev_ce) begin
        if (mem_addr === 23'h000100) pg++;
        else if (mem_addr === 23'h7FFFF0) begin
          dg++;
          if (pg_at_dma < 0) pg_at_dma = pg;
        end
      end
      prev_ce = mem_ce;
      if (ppu_done) ppu_req = 1'b1;
      if (dma_ack) dma_req = 1'b0;
    end
    ppu_req = 1'b0;
    dma_req = 1'b0;
`ifdef CHR_ARB_FAIRNESS_EN
    checks++;
    if (pg_at_dma !== 8 || dg !== 1) begin
      failures++;
      $display("FAIL fairness_slot: got ppu_grants_before_dma=%0d dma_grants=%0d required 8/1",
               pg_at_dma, dg);
    end
`else
    checks++;
    if (dg !== 0 || pg < 12) begin
      failures++;
      $display("FAIL strict_priority: got dma_grants=%0d ppu_grants=%0d required 0/>=12", dg, pg);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int acks, ce_seen;
    do_reset();
    acks = 0; ce_seen = 0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 23'h0ABCDE; mem_rdat = 8'h99;
    tick();
    tick();
    checks++;
    if (mem_ce !== 1'b1) begin
      failures++;
      $display("FAIL midrst_active: got ce=%b required 1", mem_ce);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_ce, mem_oe, mem_we, mem_addr, mem_wdat, ppu_rdat, dma_rdat,
         ppu_done, dma_ack, ppu_ovr} !== 53'd0) begin
      failures++;
      $display("FAIL midrst_async: got ce=%b oe=%b addr=%h dma_rdat=%h required all zero",
               mem_ce, mem_oe, mem_addr, dma_rdat);
    end
    dma_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (dma_ack) acks++;
      if (mem_ce) ce_seen++;
    end
    checks++;
    if (acks !== 0 || ce_seen !== 0) begin
      failures++;
      $display("FAIL midrst_abandon: got acks=%0d ce_cycles=%0d required 0/0", acks, ce_seen);
    end
  endtask

  initial begin
    test_reset();
    test_ppu_read();
    test_dma_write();
    test_ppu_behind_dma();
    test_overrun();
    test_back_to_back();
    test_priority();
    test_starvation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
